snake_plotter: RTL and testbench
================================

SNAKE_PLOTTER -- requirements
Module: snake_plotter

Interface
REQ-001 The module SHALL have the port: CLOCK_50  input  1  system clock, all logic on its rising edge.
REQ-002 The module SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-003 The module SHALL have the port: start  input  1  request pulse, sampled only in IDLE.
REQ-004 The module SHALL have the port: clear  input  1  sampled with start; 1 = full-screen clear, 0 = single 4x4 cell.
REQ-005 The module SHALL have the port: erase  input  1  sampled with start; 1 = cell drawn in colour 3'b000.
REQ-006 The module SHALL have the ports x_in  input  8  and y_in  input  7, the cell top-left pixel, latched on accept.
REQ-007 The module SHALL have the port: colour_in  input  3  cell colour, latched on accept.
REQ-008 The module SHALL have the ports vga_x  output  8,  vga_y  output  7  and  vga_colour  output  3, the registered pixel to write.
REQ-009 The module SHALL have the port: vga_plot  output  1  registered pixel-write strobe.
REQ-010 The module SHALL have the port: busy  output  1  high in any state other than IDLE.
REQ-011 The module SHALL have the port: done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have the states IDLE, CELL, CLR and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted and SHALL latch clear, erase, x_in, y_in and colour_in; the next state is CLR if clear=1, else CELL.
REQ-014 start SHALL be ignored in every state except IDLE; no queuing.
REQ-015 CELL SHALL last exactly 16 cycles, using 2-bit counters col and row.
REQ-016 In CELL, the outputs SHALL be: vga_x = x_lat + col (8-bit, wraps mod 256) and vga_y = y_lat + row (7-bit, wraps mod 128).
REQ-017 Scan order SHALL be row-major with col fastest: (0,0), (1,0) ... (3,0), (0,1) ... (3,3).
REQ-018 vga_colour in CELL SHALL be 3'b000 if erase_lat=1, else colour_lat.
REQ-019 CLR SHALL last exactly 19200 cycles, covering x 0..159 and y 0..119 with x fastest; vga_colour SHALL be 3'b000 throughout.
REQ-020 vga_plot SHALL be 1 in every CELL and CLR cycle (subject to REQ-027) and 0 in IDLE and DONE.
REQ-021 The first pixel SHALL appear on the outputs the cycle after accept; outputs SHALL be registered.
REQ-022 After the last pixel the FSM SHALL enter DONE for exactly one cycle with done=1, busy=1 and vga_plot=0, then return to IDLE.
REQ-023 In IDLE and DONE, vga_x, vga_y and vga_colour SHALL hold their last values.
REQ-024 If start=1 coincides with the DONE cycle, it SHALL be ignored; it is accepted only in the following IDLE cycle.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE from any state and abort any operation in progress.
REQ-026 On reset, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0, all counters=0 and all latches=0; reset SHALL take priority over start.

Configuration
REQ-027 With PLOTTER_CLIP_EN defined, vga_plot SHALL be forced to 0 for any CELL pixel with vga_x>159 or vga_y>119; cycle count and done timing SHALL be unchanged.
REQ-028 Without PLOTTER_CLIP_EN, all 16 CELL pixels SHALL be plotted with the wrapped coordinates of REQ-016.

Verification
REQ-029 Bench SHALL check: start, clear=0, erase=0, x_in=60, y_in=60, colour_in=3'b010 -> 16 plots over x 60..63 and y 60..63 in row-major order, colour 010, done on cycle 17 after accept, busy high cycles 1..17.
REQ-030 Bench SHALL check: the same request with erase=1 and colour_in=3'b110 -> identical coordinates with vga_colour=000.
REQ-031 Bench SHALL check: start with clear=1 -> exactly 19200 plot cycles, first pixel (0,0), last pixel (159,119), colour 000, then a single done pulse.
REQ-032 Bench SHALL check: start pulses during CELL and during DONE -> ignored, exactly one done, no extra plots.
REQ-033 Bench SHALL check: reset asserted at CLR pixel 5000 -> the next cycle shows IDLE with all outputs 0; a new cell request then completes normally.
REQ-034 Bench SHALL check: x_in=158, y_in=118 -> with PLOTTER_CLIP_EN, plot=1 only for x 158..159 and y 118..119 (4 pixels) and done still on cycle 17; without it, 16 plots with x 158..161.

Source files
------------

// File: rtl/snake_plotter.sv
// Snake-game pixel plotter: draws one 4x4 cell or clears the 160x120 screen, one pixel per clock.
// Optional build macro PLOTTER_CLIP_EN suppresses the write strobe for cell pixels that fall off-screen.
module snake_plotter (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic       erase,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, CELL, CLR, DONE} state_t;

    state_t     r_state;
    logic       r_clearLat;
    logic       r_eraseLat;
    logic [7:0] r_xLat;
    logic [6:0] r_yLat;
    logic [2:0] r_colourLat;
    logic [1:0] r_col;
    logic [1:0] r_row;
    logic [7:0] r_clrX;
    logic [6:0] r_clrY;
    logic [7:0] r_vgaX;
    logic [6:0] r_vgaY;
    logic [2:0] r_vgaColour;
    logic       r_vgaPlot;
    logic       r_busy;
    logic       r_done;

    logic [1:0] w_nextCol;
    logic [1:0] w_nextRow;
    logic [7:0] w_cellX;
    logic [6:0] w_cellY;
    logic       w_cellLast;
    logic [7:0] w_clrNextX;
    logic [6:0] w_clrNextY;
    logic       w_clrLast;
    logic [2:0] w_drawColour;
    logic       w_cellVisible;
    logic       w_acceptVisible;

    // Counters hold the pixel currently on the outputs; the next pixel is computed ahead.
    assign w_nextCol    = r_col + 2'd1;
    assign w_nextRow    = (r_col == 2'd3) ? r_row + 2'd1 : r_row;
    assign w_cellX      = r_xLat + {6'd0, w_nextCol};
    assign w_cellY      = r_yLat + {5'd0, w_nextRow};
    assign w_cellLast   = (r_col == 2'd3) && (r_row == 2'd3);
    assign w_clrNextX   = (r_clrX == 8'd159) ? 8'd0 : r_clrX + 8'd1;
    assign w_clrNextY   = (r_clrX == 8'd159) ? r_clrY + 7'd1 : r_clrY;
    assign w_clrLast    = (r_clrX == 8'd159) && (r_clrY == 7'd119);
    assign w_drawColour = (r_eraseLat || r_clearLat) ? 3'b000 : r_colourLat;

`ifdef PLOTTER_CLIP_EN
    assign w_cellVisible   = (w_cellX <= 8'd159) && (w_cellY <= 7'd119);
    assign w_acceptVisible = (x_in <= 8'd159) && (y_in <= 7'd119);
`else
    assign w_cellVisible   = 1'b1;
    assign w_acceptVisible = 1'b1;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= IDLE;
            r_clearLat  <= 1'b0;
            r_eraseLat  <= 1'b0;
            r_xLat      <= 8'd0;
            r_yLat      <= 7'd0;
            r_colourLat <= 3'd0;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_clrX      <= 8'd0;
            r_clrY      <= 7'd0;
            r_vgaX      <= 8'd0;
            r_vgaY      <= 7'd0;
            r_vgaColour <= 3'd0;
            r_vgaPlot   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    // The first pixel goes out on the accept edge itself.
                    if (start) begin
                        r_clearLat  <= clear;
                        r_eraseLat  <= erase;
                        r_xLat      <= x_in;
                        r_yLat      <= y_in;
                        r_colourLat <= colour_in;
                        r_col       <= 2'd0;
                        r_row       <= 2'd0;
                        r_clrX      <= 8'd0;
                        r_clrY      <= 7'd0;
                        r_busy      <= 1'b1;
                        r_vgaX      <= clear ? 8'd0 : x_in;
                        r_vgaY      <= clear ? 7'd0 : y_in;
                        r_vgaColour <= (clear || erase) ? 3'b000 : colour_in;
                        r_vgaPlot   <= clear ? 1'b1 : w_acceptVisible;
                        r_state     <= clear ? CLR : CELL;
                    end
                end
                CELL: begin
                    if (w_cellLast) begin
                        r_vgaPlot <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_col       <= w_nextCol;
                        r_row       <= w_nextRow;
                        r_vgaX      <= w_cellX;
                        r_vgaY      <= w_cellY;
                        r_vgaColour <= w_drawColour;
                        r_vgaPlot   <= w_cellVisible;
                    end
                end
                CLR: begin
                    if (w_clrLast) begin
                        r_vgaPlot <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_clrX      <= w_clrNextX;
                        r_clrY      <= w_clrNextY;
                        r_vgaX      <= w_clrNextX;
                        r_vgaY      <= w_clrNextY;
                        r_vgaColour <= w_drawColour;
                        r_vgaPlot   <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vga_x      = r_vgaX;
    assign vga_y      = r_vgaY;
    assign vga_colour = r_vgaColour;
    assign vga_plot   = r_vgaPlot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_snake_plotter.sv
// Scoreboard bench for snake_plotter: stimulus queues expected pixels/done cycles, a negedge monitor checks them.
// Expectations follow PLOTTER_CLIP_EN when the bench is built with it.
module tb_snake_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic       clear;
    logic       erase;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } pix_t;

    pix_t pxQ[$];
    int   doneQ[$];
    int   cycleNo     = 0;
    int   busyStart   = 0;
    int   busyEnd     = -1;
    bit   monitorOn   = 1'b0;
    int   nCompared   = 0;
    int   nMismatched = 0;

    snake_plotter dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .erase     (erase),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleNo, act, exp);
        end
    endtask

    // Issue one request; start is high during the current cycle s, pixel i is due at s+1+i.
    task automatic applyStimulus(input bit clr, input bit ers, input int x, input int y, input int col);
        int s;
        int px;
        int py;
        bit vis;
        s         = cycleNo;
        clear     = clr;
        erase     = ers;
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 3'(col);
        start     = 1'b1;
        if (clr) begin
            for (int yy = 0; yy < 120; yy++)
                for (int xx = 0; xx < 160; xx++)
                    pxQ.push_back('{s + 1 + yy * 160 + xx, xx, yy, 0});
            doneQ.push_back(s + 19201);
            busyEnd = s + 19201;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    px  = (x + c) % 256;
                    py  = (y + r) % 128;
                    vis = 1'b1;
`ifdef PLOTTER_CLIP_EN
                    vis = (px <= 159) && (py <= 119);
`endif
                    if (vis) pxQ.push_back('{s + 1 + r * 4 + c, px, py, ers ? 0 : col});
                end
            end
            doneQ.push_back(s + 17);
            busyEnd = s + 17;
        end
        busyStart = s + 1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Monitor: retire overdue pixels as misses, then match the presented pixel and done pulse.
    always @(negedge CLOCK_50) begin : monitor
        pix_t e;
        int   d;
        if (monitorOn) begin
            while (pxQ.size() > 0 && pxQ[0].cyc < cycleNo) begin
                e = pxQ.pop_front();
                checkOutput("missedPlotCycle", -1, e.cyc);
            end
            if (vga_plot) begin
                if (pxQ.size() > 0 && pxQ[0].cyc == cycleNo) begin
                    e = pxQ.pop_front();
                    checkOutput("plotX", int'(vga_x), e.x);
                    checkOutput("plotY", int'(vga_y), e.y);
                    checkOutput("plotColour", int'(vga_colour), e.c);
                end else begin
                    checkOutput("extraPlotCycle", cycleNo, -1);
                end
            end
            while (doneQ.size() > 0 && doneQ[0] < cycleNo) begin
                d = doneQ.pop_front();
                checkOutput("missedDoneCycle", -1, d);
            end
            if (done) begin
                if (doneQ.size() > 0 && doneQ[0] == cycleNo) begin
                    d = doneQ.pop_front();
                    checkOutput("doneCycle", cycleNo, d);
                    checkOutput("plotAtDone", int'(vga_plot), 0);
                end else begin
                    checkOutput("extraDoneCycle", cycleNo, -1);
                end
            end
            checkOutput("busy", int'(busy), (cycleNo >= busyStart && cycleNo <= busyEnd) ? 1 : 0);
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_x"}, int'(vga_x), 0);
        checkOutput({tag, "_y"}, int'(vga_y), 0);
        checkOutput({tag, "_colour"}, int'(vga_colour), 0);
        checkOutput({tag, "_plot"}, int'(vga_plot), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int s;
        reset     = 1'b1;
        start     = 1'b0;
        clear     = 1'b0;
        erase     = 1'b0;
        x_in      = 8'd0;
        y_in      = 7'd0;
        colour_in = 3'd0;
        idleCycles(3);
        checkAllZero("reset");
        reset     = 1'b0;
        monitorOn = 1'b1;
        idleCycles(2);

        $display("[TB] cell draw at (60,60) colour 010");
        applyStimulus(1'b0, 1'b0, 60, 60, 2);
        idleCycles(25);

        $display("[TB] cell erase at (60,60)");
        applyStimulus(1'b0, 1'b1, 60, 60, 6);
        idleCycles(25);

        $display("[TB] start pulses during CELL and DONE");
        applyStimulus(1'b0, 1'b0, 10, 20, 5);
        s = cycleNo - 1;
        idleCycles(4);
        x_in  = 8'd100;
        clear = 1'b1;
        start = 1'b1;
        idleCycles(1);
        start = 1'b0;
        idleCycles(s + 17 - cycleNo);
        start = 1'b1;
        idleCycles(1);
        start = 1'b0;
        clear = 1'b0;
        idleCycles(25);

        $display("[TB] full-screen clear");
        applyStimulus(1'b1, 1'b0, 0, 0, 7);
        idleCycles(19210);

        $display("[TB] cell near bottom-right corner (158,118)");
        applyStimulus(1'b0, 1'b0, 158, 118, 7);
        idleCycles(25);

        $display("[TB] reset during clear");
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        s = cycleNo - 1;
        idleCycles(4999);
        reset   = 1'b1;
        busyEnd = s + 5000;
        idleCycles(1);
        reset = 1'b0;
        pxQ.delete();
        doneQ.delete();
        checkAllZero("abort");
        idleCycles(2);
        applyStimulus(1'b0, 1'b0, 60, 60, 2);
        idleCycles(25);

        checkOutput("pixelsOutstanding", pxQ.size(), 0);
        checkOutput("donesOutstanding", doneQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
